// File: rtl/neopixel_pkg.sv
// Shared types for the NeoPixel frame path: frame layout, channel order and
// sequencer states.
package neopixel_pkg;

  localparam int NUM_PIXELS  = 5;
  localparam int NUM_ENTRIES = 63;

  typedef logic [23:0] pixel_t;
  typedef pixel_t [NUM_PIXELS-1:0] frame_t;

  // Channel order inside a pixel word: G in [23:16], R in [15:8], B in [7:0].
  typedef enum logic [1:0] {CH_G, CH_R, CH_B} channel_e;

  typedef enum logic [1:0] {WAIT, LOAD, PRESENT} state_e;

  // Channel of the following entry; wraps B back to G.
  function automatic channel_e next_channel(input channel_e ch);
    case (ch)
      CH_G:    return CH_R;
      CH_R:    return CH_B;
      default: return CH_G;
    endcase
  endfunction

endpackage

// File: rtl/tick_timer.sv
// Free-running refresh timer counting 0..TICK_CYCLES-1 while enabled; emits
// a one-cycle tick on the terminal count and wraps to 0.
module tick_timer #(
  parameter int TICK_CYCLES = 2_500_000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  // Next count: clear wins, otherwise advance while enabled and wrap at LAST.
  always_comb begin
    count_d = count_q;
    tick    = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      if (count_q == LAST) begin
        tick    = 1'b1;
        count_d = '0;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  // Count register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/pattern_loader.sv
// Walks the pattern arrays one entry per cycle, writing each color byte into
// one channel of the GRB frame register, and hands the finished frame to the
// serial driver.
//
// Handshake: frame_valid is registered and, once high, stays high with
// frame_data frozen until a cycle where frame_valid && frame_ready; the
// transfer happens on that clock edge and frame_valid is low afterwards.
module pattern_loader #(
  parameter int NUM_PIXELS  = 5,
  parameter int NUM_ENTRIES = 63,
  parameter int TICK_CYCLES = 2_500_000
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_ENTRIES-1:0][7:0]      color_array,
  input  logic [NUM_ENTRIES-1:0][2:0]      pixel_array,
  input  logic [6:0]                       max_num_loads,
  input  logic [1:0]                       pattern_sel,
  input  logic                             hold,
  input  logic                             frame_ready,
  output logic [NUM_PIXELS-1:0][23:0]      frame_data,
  output logic                             frame_valid,
  output logic [5:0]                       load_index,
  output neopixel_pkg::state_e             state_dbg
);

  import neopixel_pkg::state_e;
  import neopixel_pkg::channel_e;
  import neopixel_pkg::WAIT;
  import neopixel_pkg::LOAD;
  import neopixel_pkg::PRESENT;
  import neopixel_pkg::CH_G;
  import neopixel_pkg::CH_R;
  import neopixel_pkg::next_channel;

  localparam logic [5:0] LAST_IDX = 6'(NUM_ENTRIES - 1);

  state_e                        state_q, state_d;
  logic [5:0]                    idx_q, idx_d;
  channel_e                      ch_q, ch_d;
  logic [6:0]                    cnt_q, cnt_d;
  logic [6:0]                    n_q, n_d;
  logic [NUM_PIXELS-1:0][23:0]   frame_q, frame_d;
  logic                          valid_q, valid_d;
  logic [1:0]                    pat_q, pat_d;
  logic                          pend_q, pend_d;

  logic       tick;
  logic       handshake;
  logic       apply;
  logic       timer_en;
  logic       timer_clr;
  logic [2:0] cur_pix;
  logic [7:0] cur_color;

  assign handshake = valid_q && frame_ready;
  // A pending restart waits for the handshake in PRESENT so valid never drops alone.
  assign apply     = pend_q && ((state_q != PRESENT) || handshake);
  assign timer_en  = (state_q == WAIT) && !hold && !pend_q;
  assign timer_clr = apply || handshake;
  assign cur_pix   = pixel_array[idx_q];
  assign cur_color = color_array[idx_q];

  tick_timer #(
    .TICK_CYCLES (TICK_CYCLES)
  ) u_tick_timer (
    .clock  (clock),
    .reset  (reset),
    .enable (timer_en),
    .clear  (timer_clr),
    .tick   (tick)
  );

  // Sequencer next state, frame writes and pattern-restart handling.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    frame_d = frame_q;
    valid_d = valid_q;
    pat_d   = pat_q;
    pend_d  = pend_q | (pattern_sel != pat_q);

    if (apply) begin
      state_d = WAIT;
      idx_d   = '0;
      ch_d    = CH_G;
      cnt_d   = '0;
      frame_d = '0;
      valid_d = 1'b0;
      pat_d   = pattern_sel;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        WAIT: begin
          if (tick) begin
            state_d = LOAD;
            n_d     = (max_num_loads == 7'd0) ? 7'd1 : max_num_loads;
          end
        end
        LOAD: begin
          if (!hold) begin
            // Out-of-range pixel indices match no slot, so the write is dropped.
            for (int p = 0; p < NUM_PIXELS; p++) begin
              if (cur_pix == 3'(p)) begin
                case (ch_q)
                  CH_G:    frame_d[p][23:16] = cur_color;
                  CH_R:    frame_d[p][15:8]  = cur_color;
                  default: frame_d[p][7:0]   = cur_color;
                endcase
              end
            end
            idx_d = (idx_q == LAST_IDX) ? 6'd0 : idx_q + 6'd1;
            ch_d  = next_channel(ch_q);
            if (cnt_q == n_q - 7'd1) begin
              cnt_d   = '0;
              state_d = PRESENT;
              valid_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 7'd1;
            end
          end
        end
        PRESENT: begin
          if (handshake) begin
            valid_d = 1'b0;
            state_d = WAIT;
          end
        end
        default: state_d = WAIT;
      endcase
    end
  end

  // State, counters, frame and pattern-copy registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= WAIT;
      idx_q   <= '0;
      ch_q    <= CH_G;
      cnt_q   <= '0;
      n_q     <= 7'd1;
      frame_q <= '0;
      valid_q <= 1'b0;
      pat_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      frame_q <= frame_d;
      valid_q <= valid_d;
      pat_q   <= pat_d;
      pend_q  <= pend_d;
    end
  end

  assign frame_data  = frame_q;
  assign frame_valid = valid_q;
  assign load_index  = idx_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_pattern_loader.sv
// Directed bench for pattern_loader with a 4-cycle refresh timer.
module tb_pattern_loader;
  import neopixel_pkg::*;

  logic              clock;
  logic              reset;
  logic [62:0][7:0]  color_array;
  logic [62:0][2:0]  pixel_array;
  logic [6:0]        max_num_loads;
  logic [1:0]        pattern_sel;
  logic              hold;
  logic              frame_ready;
  logic [4:0][23:0]  frame_data;
  logic              frame_valid;
  logic [5:0]        load_index;
  state_e            state_dbg;

  int total = 0;
  int bad   = 0;
  logic [4:0][23:0] exp_f;

  pattern_loader #(
    .NUM_PIXELS  (5),
    .NUM_ENTRIES (63),
    .TICK_CYCLES (4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .color_array   (color_array),
    .pixel_array   (pixel_array),
    .max_num_loads (max_num_loads),
    .pattern_sel   (pattern_sel),
    .hold          (hold),
    .frame_ready   (frame_ready),
    .frame_data    (frame_data),
    .frame_valid   (frame_valid),
    .load_index    (load_index),
    .state_dbg     (state_dbg)
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Steps until frame_valid is seen, bounded; returns edges taken.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (frame_valid !== 1'b1 && cyc < 300) begin
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    int cyc;
    #22;
    total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", frame_valid); end
    total++; if (frame_data !== '0) begin bad++; $display("FAIL rst_frame got=%h want=0", frame_data); end
    total++; if (load_index !== 6'd0) begin bad++; $display("FAIL rst_index got=%0d want=0", load_index); end
    total++; if (state_dbg !== WAIT) begin bad++; $display("FAIL rst_state got=%0d want=%0d", state_dbg, WAIT); end
    reset = 1'b1;
    wait_valid(cyc);
    total++; if (cyc != 19) begin bad++; $display("FAIL first_latency got=%0d want=19", cyc); end
    total++; if (load_index !== 6'd15) begin bad++; $display("FAIL first_index got=%0d want=15", load_index); end
  endtask

  task automatic test_channel_write();
    exp_f = '0;
    exp_f[2] = 24'hAABB00;
    exp_f[0] = 24'h000011;
    total++; if (frame_data[2] !== 24'hAABB00) begin bad++; $display("FAIL px2 got=%h want=aabb00", frame_data[2]); end
    total++; if (frame_data[0] !== 24'h000011) begin bad++; $display("FAIL px0 got=%h want=000011", frame_data[0]); end
    total++; if (frame_data !== exp_f) begin bad++; $display("FAIL frame_all got=%h want=%h", frame_data, exp_f); end
  endtask

  task automatic test_backpressure();
    int cyc;
    step();
    total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL hs1_valid got=%b want=0", frame_valid); end
    frame_ready = 1'b0;
    wait_valid(cyc);
    total++; if (cyc != 19) begin bad++; $display("FAIL f2_latency got=%0d want=19", cyc); end
    total++; if (load_index !== 6'd30) begin bad++; $display("FAIL f2_index got=%0d want=30", load_index); end
    for (int k = 0; k < 10; k++) begin
      step();
      total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL bp_valid cyc=%0d got=%b want=1", k, frame_valid); end
      total++; if (frame_data !== exp_f) begin bad++; $display("FAIL bp_frame cyc=%0d got=%h want=%h", k, frame_data, exp_f); end
    end
    frame_ready = 1'b1;
    step();
    total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b want=0", frame_valid); end
    wait_valid(cyc);
    total++; if (cyc != 19) begin bad++; $display("FAIL f3_latency got=%0d want=19", cyc); end
    total++; if (load_index !== 6'd45) begin bad++; $display("FAIL f3_index got=%0d want=45", load_index); end
  endtask

  task automatic test_wrap();
    int cyc;
    step();
    wait_valid(cyc);
    total++; if (load_index !== 6'd60) begin bad++; $display("FAIL f4_index got=%0d want=60", load_index); end
    step();
    wait_valid(cyc);
    total++; if (cyc != 19) begin bad++; $display("FAIL f5_latency got=%0d want=19", cyc); end
    total++; if (load_index !== 6'd12) begin bad++; $display("FAIL f5_index got=%0d want=12", load_index); end
    total++; if (frame_data !== exp_f) begin bad++; $display("FAIL f5_frame got=%h want=%h", frame_data, exp_f); end
    max_num_loads = 7'd0;
    step();
    wait_valid(cyc);
    total++; if (cyc != 5) begin bad++; $display("FAIL min_latency got=%0d want=5", cyc); end
    total++; if (load_index !== 6'd13) begin bad++; $display("FAIL min_index got=%0d want=13", load_index); end
    step();
    wait_valid(cyc);
    total++; if (load_index !== 6'd14) begin bad++; $display("FAIL min_index2 got=%0d want=14", load_index); end
  endtask

  task automatic test_large();
    int cyc;
    step();
    color_array[0] = 8'h5A;
    max_num_loads  = 7'd100;
    frame_ready    = 1'b0;
    wait_valid(cyc);
    exp_f[2] = 24'h5ABB00;
    total++; if (cyc != 104) begin bad++; $display("FAIL big_latency got=%0d want=104", cyc); end
    total++; if (load_index !== 6'd51) begin bad++; $display("FAIL big_index got=%0d want=51", load_index); end
    total++; if (frame_data !== exp_f) begin bad++; $display("FAIL big_frame got=%h want=%h", frame_data, exp_f); end
  endtask

  task automatic test_pattern_restart();
    pattern_sel = 2'b01;
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL pat_hold_valid cyc=%0d got=%b want=1", k, frame_valid); end
    end
    total++; if (frame_data !== exp_f) begin bad++; $display("FAIL pat_hold_frame got=%h want=%h", frame_data, exp_f); end
    frame_ready   = 1'b1;
    max_num_loads = 7'd6;
    step();
    total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL pat_valid got=%b want=0", frame_valid); end
    total++; if (frame_data !== '0) begin bad++; $display("FAIL pat_frame got=%h want=0", frame_data); end
    total++; if (load_index !== 6'd0) begin bad++; $display("FAIL pat_index got=%0d want=0", load_index); end
    total++; if (state_dbg !== WAIT) begin bad++; $display("FAIL pat_state got=%0d want=%0d", state_dbg, WAIT); end
  endtask

  task automatic test_skip();
    for (int k = 0; k < 4; k++) step();
    total++; if (state_dbg !== LOAD) begin bad++; $display("FAIL skip_state got=%0d want=%0d", state_dbg, LOAD); end
    exp_f = '0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (k == 0) exp_f[2] = 24'h5A0000;
      if (k == 1) exp_f[2] = 24'h5ABB00;
      if (k == 2) exp_f[0] = 24'h000011;
      total++; if (frame_data !== exp_f) begin bad++; $display("FAIL skip_frame k=%0d got=%h want=%h", k, frame_data, exp_f); end
      total++; if (load_index !== 6'(k + 1)) begin bad++; $display("FAIL skip_index k=%0d got=%0d want=%0d", k, load_index, k + 1); end
    end
    total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL skip_valid got=%b want=1", frame_valid); end
  endtask

  task automatic test_hold();
    int cyc;
    step();
    total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL hold_hs got=%b want=0", frame_valid); end
    hold = 1'b1;
    step();
    step();
    hold = 1'b0;
    for (int k = 0; k < 3; k++) step();
    total++; if (state_dbg !== WAIT) begin bad++; $display("FAIL hold_wait_state got=%0d want=%0d", state_dbg, WAIT); end
    step();
    total++; if (state_dbg !== LOAD) begin bad++; $display("FAIL hold_load_state got=%0d want=%0d", state_dbg, LOAD); end
    step();
    step();
    total++; if (load_index !== 6'd8) begin bad++; $display("FAIL hold_pre_index got=%0d want=8", load_index); end
    hold = 1'b1;
    for (int k = 0; k < 3; k++) step();
    total++; if (load_index !== 6'd8) begin bad++; $display("FAIL hold_stall_index got=%0d want=8", load_index); end
    total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL hold_stall_valid got=%b want=0", frame_valid); end
    hold = 1'b0;
    wait_valid(cyc);
    total++; if (cyc != 4) begin bad++; $display("FAIL hold_rest got=%0d want=4", cyc); end
    total++; if (load_index !== 6'd12) begin bad++; $display("FAIL hold_index got=%0d want=12", load_index); end
    hold = 1'b1;
    step();
    total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL hold_present got=%b want=0", frame_valid); end
    hold = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 6; k++) step();
    total++; if (state_dbg !== LOAD) begin bad++; $display("FAIL ar_state_pre got=%0d want=%0d", state_dbg, LOAD); end
    total++; if (frame_data !== exp_f) begin bad++; $display("FAIL ar_frame_pre got=%h want=%h", frame_data, exp_f); end
    #2;
    reset = 1'b0;
    #1;
    total++; if (frame_data !== '0) begin bad++; $display("FAIL ar_frame got=%h want=0", frame_data); end
    total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%b want=0", frame_valid); end
    total++; if (load_index !== 6'd0) begin bad++; $display("FAIL ar_index got=%0d want=0", load_index); end
    total++; if (state_dbg !== WAIT) begin bad++; $display("FAIL ar_state got=%0d want=%0d", state_dbg, WAIT); end
    #10;
    reset = 1'b1;
  endtask

  initial begin
    reset         = 1'b0;
    max_num_loads = 7'd15;
    pattern_sel   = 2'b00;
    hold          = 1'b0;
    frame_ready   = 1'b1;
    for (int i = 0; i < 63; i++) begin
      pixel_array[i] = 3'd7;
      color_array[i] = 8'hC3;
    end
    pixel_array[0] = 3'd2; color_array[0] = 8'hAA;
    pixel_array[1] = 3'd2; color_array[1] = 8'hBB;
    pixel_array[2] = 3'd0; color_array[2] = 8'h11;
    pixel_array[3] = 3'd5; color_array[3] = 8'h77;
    pixel_array[4] = 3'd6; color_array[4] = 8'h66;
    pixel_array[5] = 3'd7; color_array[5] = 8'h55;

    test_reset();
    test_channel_write();
    test_backpressure();
    test_wrap();
    test_large();
    test_pattern_restart();
    test_skip();
    test_hold();
    test_async_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
